// File: rtl/button_conditioner.sv
// button_conditioner: conditions one raw key input for the game FSM and step counter.
//   2-FF synchronizer -> debounce filter -> registered level plus edge / long-press pulses.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   btn_raw       in   asynchronous raw key pin (polarity set by ACTIVE_LOW)
//   level         out  debounced pressed state (1 = pressed)
//   press         out  one-cycle pulse on level 0->1
//   release_pulse out  one-cycle pulse on level 1->0 ('release' is a reserved word in SV)
//   tap           out  one-cycle pulse with release_pulse when no hold fired this press
//   hold          out  one-cycle pulse after HOLD_CYCLES of continuous press
//   held          out  high from the hold pulse until the release edge
//
// Every output is a flop; btn_raw has no combinational path to any output.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic tap,
  output logic hold,
  output logic held
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0]   DbOne    = DbW'(1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  // Raw pin value when the key is not pressed.
  localparam logic RawIdle = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             tap_q, tap_d;
  logic             hold_q, hold_d;
  logic             held_q, held_d;

  logic             sample;
  logic             toggle;
  logic             rise;
  logic             fall;

  always_comb begin
    sample     = sync2_q ^ ACTIVE_LOW;
    toggle     = 1'b0;
    db_cnt_d   = '0;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
    held_d     = held_q;

    // Any sample equal to level restarts the qualification window.
    if (sample != level_q) begin
      if (db_cnt_q == DbLast) begin
        toggle = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DbOne;
      end
    end

    level_d = level_q ^ toggle;
    rise    = toggle & ~level_q;
    fall    = toggle & level_q;

    // Counter is zero while released and restarts on the press edge; it saturates so
    // hold_cnt_q == HoldLast is seen only once per press.
    if (!level_q || toggle) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + HoldOne;
    end

    // A release on the same edge suppresses the hold pulse.
    hold_d = level_q & ~toggle & (hold_cnt_q == HoldLast);

    if (fall) begin
      held_d = 1'b0;
    end else if (hold_d) begin
      held_d = 1'b1;
    end

    press_d   = rise;
    release_d = fall;
    // held_q is set exactly when a hold fired during the current press.
    tap_d     = fall & ~held_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= RawIdle;
      sync2_q    <= RawIdle;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      tap_q      <= 1'b0;
      hold_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      tap_q      <= tap_d;
      hold_q     <= hold_d;
      held_q     <= held_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign tap           = tap_q;
  assign hold          = hold_q;
  assign held          = held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one active-low and one active-high instance driven with
// mirrored pins so both must produce identical event timing. Stimulus pushes expected
// events {cycle, outputs} into per-instance queues; a negedge monitor pops one entry
// whenever an instance shows any pulse.
module tb_button_conditioner;

  localparam int unsigned Db = 4;
  localparam int unsigned Hc = 10;

  // Output vector order: {level, press, release, tap, hold, held}
  localparam logic [5:0] EvPress  = 6'b110000;
  localparam logic [5:0] EvHold   = 6'b100011;
  localparam logic [5:0] EvRelTap = 6'b001100;
  localparam logic [5:0] EvRel    = 6'b001000;

  logic clk = 1'b0;
  logic rst;
  logic btn_a;
  logic btn_b;

  logic level_a, press_a, rel_a, tap_a, hold_a, held_a;
  logic level_b, press_b, rel_b, tap_b, hold_b, held_b;
  logic [5:0] out_a, out_b;

  assign btn_b = ~btn_a;
  assign out_a = {level_a, press_a, rel_a, tap_a, hold_a, held_a};
  assign out_b = {level_b, press_b, rel_b, tap_b, hold_b, held_b};

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .HOLD_CYCLES    (Hc),
    .ACTIVE_LOW     (1'b1)
  ) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_a),
    .level        (level_a),
    .press        (press_a),
    .release_pulse(rel_a),
    .tap          (tap_a),
    .hold         (hold_a),
    .held         (held_a)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .HOLD_CYCLES    (Hc),
    .ACTIVE_LOW     (1'b0)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_b),
    .level        (level_b),
    .press        (press_b),
    .release_pulse(rel_b),
    .tap          (tap_b),
    .hold         (hold_b),
    .held         (held_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] v;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic expect_ev(input int at, input logic [5:0] v);
    ev_t e;
    e.at = at;
    e.v  = v;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  task automatic check_ev(input string name, input int id, input logic [5:0] act);
    ev_t e;
    int  sz;
    n_checks++;
    sz = (id == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      n_err++;
      $display("FAIL %s unexpected event: cyc=%0d outputs=%b, required no event", name, cyc, act);
    end else begin
      if (id == 0) e = q_a.pop_front();
      else         e = q_b.pop_front();
      if (e.at != cyc || e.v != act) begin
        n_err++;
        $display("FAIL %s event: got cyc=%0d outputs=%b, required cyc=%0d outputs=%b",
                 name, cyc, act, e.at, e.v);
      end
    end
  endtask

  task automatic check_now(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc=%0d: got %b, required %b", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: any pulse on an instance must match the next expected event.
  always @(negedge clk) begin
    if (press_a | rel_a | tap_a | hold_a) check_ev("mon_al1", 0, out_a);
    if (press_b | rel_b | tap_b | hold_b) check_ev("mon_al0", 1, out_b);
  end

  initial begin
    int k;
    int p;

    // Reset with the active-low pin pressed: everything stays clear.
    rst   = 1'b0;
    btn_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_now("reset_al1", out_a, 6'b0);
    check_now("reset_al0", out_b, 6'b0);
    btn_a = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_now("idle_al1", out_a, 6'b0);
    check_now("idle_al0", out_b, 6'b0);

    // Clean press: first sampled at edge k+1, level at +5, hold 10 edges later.
    k = cyc;
    btn_a = 1'b0;
    p = k + 1 + Db + 1;
    expect_ev(p, EvPress);
    expect_ev(p + Hc, EvHold);
    wait_until(p + Hc + 1);
    check_now("held_after_hold_al1", {4'b0, hold_a, held_a}, 6'b000001);
    check_now("held_after_hold_al0", {4'b0, hold_b, held_b}, 6'b000001);
    k = cyc;
    btn_a = 1'b1;
    expect_ev(k + 6, EvRel);
    wait_until(k + 10);

    // Bounce: 3 low, 1 high, 3 low, then high must never reach level.
    btn_a = 1'b0;
    repeat (3) @(negedge clk);
    btn_a = 1'b1;
    @(negedge clk);
    btn_a = 1'b0;
    repeat (3) @(negedge clk);
    btn_a = 1'b1;
    repeat (12) @(negedge clk);
    check_now("bounce_level_al1", out_a, 6'b0);
    check_now("bounce_level_al0", out_b, 6'b0);

    // Steady low, then short tap: level high for 6 cycles.
    k = cyc;
    btn_a = 1'b0;
    p = k + 6;
    expect_ev(p, EvPress);
    expect_ev(p + 6, EvRelTap);
    wait_until(p);
    btn_a = 1'b1;
    wait_until(p + 10);

    // Long press: level high for 30 cycles, one hold, release without tap.
    k = cyc;
    btn_a = 1'b0;
    p = k + 6;
    expect_ev(p, EvPress);
    expect_ev(p + Hc, EvHold);
    wait_until(p + 20);
    check_now("held_long_al1", {5'b0, held_a}, 6'b000001);
    check_now("held_long_al0", {5'b0, held_b}, 6'b000001);
    wait_until(p + 24);
    btn_a = 1'b1;
    expect_ev(p + 30, EvRel);
    wait_until(p + 34);
    check_now("held_cleared_al1", {5'b0, held_a}, 6'b000000);

    // Release on the exact edge hold would fire: release wins, tap pulses.
    k = cyc;
    btn_a = 1'b0;
    p = k + 6;
    expect_ev(p, EvPress);
    wait_until(p + 4);
    btn_a = 1'b1;
    expect_ev(p + Hc, EvRelTap);
    wait_until(p + 14);
    check_now("coincide_idle_al1", out_a, 6'b0);
    check_now("coincide_idle_al0", out_b, 6'b0);

    // Reset while held: asynchronous clear, no release or tap afterwards.
    k = cyc;
    btn_a = 1'b0;
    p = k + 6;
    expect_ev(p, EvPress);
    expect_ev(p + Hc, EvHold);
    wait_until(p + 12);
    check_now("held_before_rst_al1", {5'b0, held_a}, 6'b000001);
    rst = 1'b0;
    #1;
    check_now("async_rst_al1", out_a, 6'b0);
    check_now("async_rst_al0", out_b, 6'b0);
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_now("post_rst_al1", out_a, 6'b0);

    // Every expected event must have been consumed.
    n_checks++;
    if (q_a.size() != 0) begin
      n_err++;
      $display("FAIL missing_events_al1: %0d pending, required 0", q_a.size());
    end
    n_checks++;
    if (q_b.size() != 0) begin
      n_err++;
      $display("FAIL missing_events_al0: %0d pending, required 0", q_b.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
